// File: rtl/video_mono_palette.sv
// Colour / monochrome output stage: expands IW-bit RGB to OW bits or maps it to a weighted luma
// for green, amber or grey monitor emulation, with a 2-stage ce-gated pipeline and matched syncs.
module video_mono_palette #(
    parameter int unsigned IW = 3,
    parameter int unsigned OW = 6,
    parameter int unsigned WR = 2,
    parameter int unsigned WG = 4,
    parameter int unsigned WB = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [1:0]    mode_req,
    input  logic          mode_now,
    input  logic          blank,
    input  logic [IW-1:0] ri,
    input  logic [IW-1:0] gi,
    input  logic [IW-1:0] bi,
    input  logic          hsync_n_i,
    input  logic          vsync_n_i,
    output logic [OW-1:0] ro,
    output logic [OW-1:0] go,
    output logic [OW-1:0] bo,
    output logic          hsync_n_o,
    output logic          vsync_n_o,
    output logic [1:0]    mode_active,
    output logic          mode_chg
);

    // Weighted sum of three IW-bit channels with 3-bit weights needs IW+5 bits; never narrower than OW.
    localparam int unsigned LW = (IW + 5 > OW) ? IW + 5 : OW;
    localparam logic [LW-1:0] LMAX = LW'((1 << OW) - 1);

    typedef enum logic [1:0] {
        MODE_COLOUR = 2'd0,
        MODE_GREEN  = 2'd1,
        MODE_AMBER  = 2'd2,
        MODE_GREY   = 2'd3
    } mode_t;

    function automatic logic [OW-1:0] replicate(input logic [IW-1:0] x);
        logic [OW-1:0] y;
        y = '0;
        for (int unsigned i = 0; i < OW; i++) begin
            y[OW-1-i] = x[IW-1-(i % IW)];
        end
        return y;
    endfunction

    mode_t         mode_cur;
    logic          vs_prev;
    logic          frame_edge;
    logic          upd;

    logic [LW-1:0] luma_raw;
    logic [OW-1:0] luma_sat;

    logic [OW-1:0] luma_s1;
    logic [OW-1:0] rep_r_s1;
    logic [OW-1:0] rep_g_s1;
    logic [OW-1:0] rep_b_s1;
    logic          blank_s1;
    mode_t         mode_s1;
    logic          hs_s1;
    logic          vs_s1;

    logic [OW-1:0] r_nx;
    logic [OW-1:0] g_nx;
    logic [OW-1:0] b_nx;

    always_comb begin
        luma_raw = LW'(WR) * LW'(ri) + LW'(WG) * LW'(gi) + LW'(WB) * LW'(bi);
        luma_sat = (luma_raw > LMAX) ? '1 : luma_raw[OW-1:0];
    end

    always_comb begin
        frame_edge = vs_prev && !vsync_n_i;
        upd        = ce && (frame_edge || mode_now) && (mode_t'(mode_req) != mode_cur);
    end

    // Mode register: the pixel sampled in the update cycle still captures the old mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_cur <= MODE_COLOUR;
            vs_prev  <= 1'b1;
            mode_chg <= 1'b0;
        end else begin
            mode_chg <= upd;
            if (ce) begin
                vs_prev <= vsync_n_i;
            end
            if (upd) begin
                mode_cur <= mode_t'(mode_req);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            luma_s1  <= '0;
            rep_r_s1 <= '0;
            rep_g_s1 <= '0;
            rep_b_s1 <= '0;
            blank_s1 <= 1'b0;
            mode_s1  <= MODE_COLOUR;
            hs_s1    <= 1'b1;
            vs_s1    <= 1'b1;
        end else if (ce) begin
            luma_s1  <= luma_sat;
            rep_r_s1 <= replicate(ri);
            rep_g_s1 <= replicate(gi);
            rep_b_s1 <= replicate(bi);
            blank_s1 <= blank;
            mode_s1  <= mode_cur;
            hs_s1    <= hsync_n_i;
            vs_s1    <= vsync_n_i;
        end
    end

    always_comb begin
        r_nx = '0;
        g_nx = '0;
        b_nx = '0;
        if (!blank_s1) begin
            case (mode_s1)
                MODE_COLOUR: begin
                    r_nx = rep_r_s1;
                    g_nx = rep_g_s1;
                    b_nx = rep_b_s1;
                end
                MODE_GREEN: begin
                    g_nx = luma_s1;
                end
                MODE_AMBER: begin
                    r_nx = luma_s1;
                    g_nx = luma_s1 >> 1;
                end
                MODE_GREY: begin
                    r_nx = luma_s1;
                    g_nx = luma_s1;
                    b_nx = luma_s1;
                end
                default: begin
                    r_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ro        <= '0;
            go        <= '0;
            bo        <= '0;
            hsync_n_o <= 1'b1;
            vsync_n_o <= 1'b1;
        end else if (ce) begin
            ro        <= r_nx;
            go        <= g_nx;
            bo        <= b_nx;
            hsync_n_o <= hs_s1;
            vsync_n_o <= vs_s1;
        end
    end

    assign mode_active = mode_cur;

endmodule

// File: tb/tb_video_mono_palette.sv
// Scoreboard bench for video_mono_palette: default-weight instance plus a saturating (all weights 7) instance.
module tb_video_mono_palette;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [1:0] mode_req;
    logic       mode_now;
    logic       blank;
    logic [2:0] ri, gi, bi;
    logic       hsync_n_i, vsync_n_i;

    logic [5:0] ro, go, bo;
    logic       hsync_n_o, vsync_n_o;
    logic [1:0] mode_active;
    logic       mode_chg;

    logic [5:0] ro2, go2, bo2;
    logic       hs2, vs2;
    logic [1:0] mode_active2;
    logic       mode_chg2;

    always #5 clk = ~clk;

    video_mono_palette #(.IW(3), .OW(6), .WR(2), .WG(4), .WB(1)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode_req(mode_req), .mode_now(mode_now), .blank(blank),
        .ri(ri), .gi(gi), .bi(bi), .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i),
        .ro(ro), .go(go), .bo(bo), .hsync_n_o(hsync_n_o), .vsync_n_o(vsync_n_o),
        .mode_active(mode_active), .mode_chg(mode_chg)
    );

    video_mono_palette #(.IW(3), .OW(6), .WR(7), .WG(7), .WB(7)) dut_sat (
        .clk(clk), .rst(rst), .ce(ce), .mode_req(mode_req), .mode_now(mode_now), .blank(blank),
        .ri(ri), .gi(gi), .bi(bi), .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i),
        .ro(ro2), .go(go2), .bo(bo2), .hsync_n_o(hs2), .vsync_n_o(vs2),
        .mode_active(mode_active2), .mode_chg(mode_chg2)
    );

    typedef struct {
        int unsigned r, g, b, r2, g2, b2, hs, vs;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    int unsigned m;
    int unsigned vsp;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // 3-bit to 6-bit replication is x*9; luma saturates at 63.
    function automatic void model(input int unsigned mode, r, g, b, bl, wr, wg, wb,
                                  output int unsigned orr, og, ob);
        int unsigned l;
        l = wr * r + wg * g + wb * b;
        if (l > 63) l = 63;
        orr = 0; og = 0; ob = 0;
        if (bl == 0) begin
            case (mode)
                0: begin orr = r * 9; og = g * 9; ob = b * 9; end
                1: og = l;
                2: begin orr = l; og = l / 2; end
                default: begin orr = l; og = l; ob = l; end
            endcase
        end
    endfunction

    task automatic compare_out(input exp_t e, input string tag);
        check({tag, ".ro"}, ro, e.r);
        check({tag, ".go"}, go, e.g);
        check({tag, ".bo"}, bo, e.b);
        check({tag, ".ro_sat"}, ro2, e.r2);
        check({tag, ".go_sat"}, go2, e.g2);
        check({tag, ".bo_sat"}, bo2, e.b2);
        check({tag, ".hsync"}, hsync_n_o, e.hs);
        check({tag, ".vsync"}, vsync_n_o, e.vs);
    endtask

    task automatic reset_model();
        exp_t z;
        z = '{r: 0, g: 0, b: 0, r2: 0, g2: 0, b2: 0, hs: 1, vs: 1};
        m   = 0;
        vsp = 1;
        sb.delete();
        sb.push_back(z);
        last = z;
    endtask

    task automatic pix(input int unsigned r, g, b, hs, vs, bl, mreq, mnow, input string tag);
        exp_t        e;
        int unsigned upd;
        ce = 1'b1; ri = 3'(r); gi = 3'(g); bi = 3'(b);
        hsync_n_i = 1'(hs); vsync_n_i = 1'(vs); blank = 1'(bl);
        mode_req = 2'(mreq); mode_now = 1'(mnow);
        model(m, r, g, b, bl, 2, 4, 1, e.r, e.g, e.b);
        model(m, r, g, b, bl, 7, 7, 7, e.r2, e.g2, e.b2);
        e.hs = hs; e.vs = vs;
        sb.push_back(e);
        upd = ((vsp == 1 && vs == 0) || mnow == 1) && (mreq != m) ? 1 : 0;
        if (upd == 1) m = mreq;
        vsp = vs;
        @(posedge clk); #1;
        e = sb.pop_front();
        compare_out(e, tag);
        last = e;
        check({tag, ".mode_active"}, mode_active, m);
        check({tag, ".mode_chg"}, mode_chg, upd);
    endtask

    task automatic gap(input string tag);
        ce = 1'b0;
        ri = 3'($urandom_range(0, 7)); gi = 3'($urandom_range(0, 7)); bi = 3'($urandom_range(0, 7));
        hsync_n_i = ~hsync_n_i; vsync_n_i = ~vsync_n_i;
        mode_req = 2'((m + 1) % 4); mode_now = 1'b1;
        @(posedge clk); #1;
        compare_out(last, tag);
        check({tag, ".mode_active"}, mode_active, m);
        check({tag, ".mode_chg"}, mode_chg, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; ce = 1'b1; ri = 3'd7; gi = 3'd7; bi = 3'd7;
        hsync_n_i = 1'b0; vsync_n_i = 1'b0; mode_req = 2'd0; mode_now = 1'b0; blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        compare_out(last, tag);
        check({tag, ".mode_active"}, mode_active, 0);
        check({tag, ".mode_chg"}, mode_chg, 0);
        rst = 1'b0;
    endtask

    initial begin
        do_reset("reset");
        pix(7, 7, 7, 0, 0, 0, 0, 0, "post_rst0");
        pix(7, 7, 7, 0, 0, 0, 0, 0, "post_rst1");
        pix(7, 7, 7, 1, 1, 0, 0, 0, "post_rst2");

        pix(5, 2, 7, 1, 1, 0, 0, 0, "colour0");
        pix(5, 2, 7, 0, 1, 0, 0, 0, "colour_hs");
        pix(1, 2, 3, 1, 1, 0, 0, 0, "colour1");
        pix(0, 6, 4, 1, 1, 0, 0, 0, "colour2");
        pix(0, 0, 0, 1, 1, 0, 0, 0, "colour3");

        pix(7, 7, 7, 1, 1, 0, 3, 1, "to_grey");
        pix(7, 7, 7, 1, 1, 0, 3, 0, "grey");
        pix(7, 7, 7, 1, 1, 0, 2, 1, "to_amber");
        pix(7, 7, 7, 1, 1, 0, 2, 0, "amber");
        pix(7, 7, 7, 1, 1, 0, 1, 1, "to_green");
        pix(7, 7, 7, 1, 1, 0, 1, 0, "green");

        pix(7, 7, 7, 1, 1, 0, 3, 1, "sat_sw");
        pix(7, 7, 7, 1, 1, 0, 3, 0, "sat_777");
        pix(1, 1, 1, 1, 1, 0, 3, 0, "sat_111");
        pix(3, 5, 2, 1, 1, 0, 3, 0, "sat_352");
        pix(0, 0, 0, 1, 1, 0, 0, 1, "sat_back");

        for (int unsigned k = 0; k < 4; k++) pix(5, 2, 7, 1, 1, 0, 3, 0, "pending");
        pix(5, 2, 7, 1, 0, 0, 3, 0, "vs_edge");
        pix(5, 2, 7, 1, 0, 0, 3, 0, "grey_after");
        pix(7, 7, 7, 1, 0, 0, 3, 0, "vs_low_hold");
        pix(7, 7, 7, 1, 1, 0, 1, 0, "vs_rise");
        pix(7, 7, 7, 1, 0, 0, 1, 1, "edge_and_now");
        pix(7, 7, 7, 1, 0, 0, 1, 1, "no_repeat");

        for (int unsigned k = 0; k < 24; k++) begin
            pix($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? 1 : 0, "rand");
        end

        for (int unsigned k = 0; k < 10; k++) begin
            pix($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                k % 2, (k / 3) % 2, (k % 4 == 1) ? 1 : 0, k % 4, (k % 3 == 0) ? 1 : 0, "ce_pix");
            gap("ce_gap");
        end
        pix(7, 7, 7, 0, 0, 1, 3, 0, "blank_sync");
        pix(7, 7, 7, 1, 1, 1, 3, 0, "blank_sync2");

        pix(7, 7, 7, 1, 1, 0, 2, 1, "pre_rst");
        do_reset("mid_reset");
        pix(3, 3, 3, 1, 0, 0, 0, 0, "after_rst0");
        pix(3, 3, 3, 1, 1, 0, 0, 0, "after_rst1");
        pix(0, 0, 0, 1, 1, 0, 0, 0, "after_rst2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
